// File: rtl/freq_sweep_seq.sv
// rtl/freq_sweep_seq.sv - freq_param ramp/triangle sweep sequencer for the PseudoPll synthesiser
module freq_sweep_seq #(
  parameter int DWELL_W = 16
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [7:0]         f_lo,
  input  logic [7:0]         f_hi,
  input  logic [7:0]         step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [7:0]         freq_param,
  output logic               busy,
  output logic               done,
  output logic               step_strobe
);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  state_t             state, state_nxt;
  logic [7:0]         freq_nxt;
  logic               busy_nxt, done_nxt, strobe_nxt;
  logic [DWELL_W-1:0] cnt, cnt_nxt;
  logic               latch;

  logic               mode_q;
  logic [7:0]         lo_q, hi_q, s_q;
  logic [DWELL_W-1:0] d_q;

  logic [8:0]         sum, diff;
  logic [7:0]         up_lvl, dn_lvl;
  logic               dwell_end;

  // 9-bit arithmetic so a large step clamps instead of wrapping
  assign sum       = {1'b0, freq_param} + {1'b0, s_q};
  assign diff      = {1'b0, freq_param} - {1'b0, s_q};
  assign up_lvl    = (sum >= {1'b0, hi_q}) ? hi_q : sum[7:0];
  assign dn_lvl    = (diff[8] || (diff[7:0] <= lo_q)) ? lo_q : diff[7:0];
  assign dwell_end = (cnt == d_q - DWELL_W'(1));

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state       <= IDLE;
      freq_param  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      step_strobe <= 1'b0;
      cnt         <= '0;
      mode_q      <= 1'b0;
      lo_q        <= '0;
      hi_q        <= '0;
      s_q         <= 8'd1;
      d_q         <= DWELL_W'(1);
    end else begin
      state       <= state_nxt;
      freq_param  <= freq_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      step_strobe <= strobe_nxt;
      cnt         <= cnt_nxt;
      if (latch) begin
        mode_q <= mode;
        lo_q   <= f_lo;
        hi_q   <= f_hi;
        s_q    <= (step == 8'd0) ? 8'd1 : step;
        d_q    <= (dwell == '0) ? DWELL_W'(1) : dwell;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    freq_nxt   = freq_param;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    strobe_nxt = 1'b0;
    cnt_nxt    = cnt;
    latch      = 1'b0;
    if (stop) begin
      state_nxt = IDLE;
      busy_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            latch      = 1'b1;
            freq_nxt   = f_lo;
            busy_nxt   = 1'b1;
            strobe_nxt = 1'b1;
            cnt_nxt    = '0;
            state_nxt  = UP;
          end
        end
        UP: begin
          if (!dwell_end) begin
            cnt_nxt = cnt + DWELL_W'(1);
          end else begin
            cnt_nxt = '0;
            if (freq_param >= hi_q) begin
              if (!mode_q) begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
              end else if (lo_q < hi_q) begin
                state_nxt = DOWN;
                freq_nxt  = dn_lvl;
              end
              // degenerate limits in triangle mode: park on f_lo
            end else begin
              freq_nxt = up_lvl;
            end
            strobe_nxt = (freq_nxt != freq_param);
          end
        end
        DOWN: begin
          if (!dwell_end) begin
            cnt_nxt = cnt + DWELL_W'(1);
          end else begin
            cnt_nxt = '0;
            if (freq_param <= lo_q) begin
              state_nxt = UP;
              freq_nxt  = up_lvl;
            end else begin
              freq_nxt = dn_lvl;
            end
            strobe_nxt = (freq_nxt != freq_param);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_sweep_seq.sv
// tb/tb_freq_sweep_seq.sv - randomized self-checking bench for freq_sweep_seq
module tb_freq_sweep_seq;
  localparam int DW = 16;

  logic          clk_in = 1'b0;
  logic          rst_n, start, stop, mode;
  logic [7:0]    f_lo, f_hi, step;
  logic [DW-1:0] dwell;
  logic [7:0]    freq_param;
  logic          busy, done, step_strobe;

  always #5 clk_in = ~clk_in;

  freq_sweep_seq #(.DWELL_W(DW)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .f_lo(f_lo), .f_hi(f_hi), .step(step), .dwell(dwell),
    .freq_param(freq_param), .busy(busy), .done(done), .step_strobe(step_strobe)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a sweep is the precomputed list of levels, each held D cycles,
  // indexed by the number of cycles elapsed since the start was accepted.
  int m_freq = 0, m_busy = 0, m_done = 0, m_strobe = 0;
  int m_active = 0, m_t = 0, m_d = 1, m_mode = 0;
  int m_levels[$];

  task automatic build_levels(input int lo, input int hi, input int s, input int md);
    int v;
    bit up;
    m_levels.delete();
    v = lo;
    m_levels.push_back(v);
    if (lo >= hi) return;
    up = 1;
    while (m_levels.size() < 400) begin
      if (up) begin
        if (v >= hi) begin
          if (md == 0) break;
          up = 0;
        end else begin
          v = (v + s > hi) ? hi : v + s;
          m_levels.push_back(v);
        end
      end else begin
        if (v <= lo) up = 1;
        else begin
          v = (v - s < lo) ? lo : v - s;
          m_levels.push_back(v);
        end
      end
    end
  endtask

  task automatic model_edge();
    int idx;
    m_done = 0;
    m_strobe = 0;
    if (!rst_n) begin
      m_freq = 0; m_busy = 0; m_active = 0;
    end else if (stop) begin
      m_busy = 0; m_active = 0;
    end else if (!m_active) begin
      if (start) begin
        m_mode = mode;
        m_d = (dwell == 0) ? 1 : int'(dwell);
        build_levels(f_lo, f_hi, (step == 0) ? 1 : int'(step), mode);
        m_t = 0; m_active = 1; m_busy = 1;
        m_freq = m_levels[0]; m_strobe = 1;
      end
    end else begin
      m_t++;
      idx = m_t / m_d;
      if (m_mode == 0 && idx >= m_levels.size()) begin
        m_active = 0; m_busy = 0; m_done = 1;
      end else begin
        if (idx >= m_levels.size()) idx = m_levels.size() - 1;
        else if (m_t % m_d == 0) m_strobe = 1;
        m_freq = m_levels[idx];
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk_in);
    model_edge();
    #1;
    check("freq_param", freq_param, m_freq);
    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("step_strobe", step_strobe, m_strobe);
  endtask

  int exp_r[13] = '{10, 10, 10, 14, 14, 14, 18, 18, 18, 20, 20, 20, 20};
  int cfg_lo[5] = '{10, 10, 250, 100, 30};
  int cfg_hi[5] = '{20, 20, 255, 255, 30};
  int cfg_st[5] = '{4, 4, 0, 200, 1};
  int cfg_dw[5] = '{3, 3, 0, 2, 5};
  int cfg_md[5] = '{0, 1, 0, 1, 0};

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
    f_lo = 8'd0; f_hi = 8'd0; step = 8'd0; dwell = '0;
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();

    // Directed single ramp against literal expectations
    f_lo = 8'd10; f_hi = 8'd20; step = 8'd4; dwell = DW'(3); mode = 1'b0;
    start = 1'b1;
    for (int k = 0; k < 13; k++) begin
      cycle();
      start = 1'b0;
      check("ramp_freq", freq_param, exp_r[k]);
      check("ramp_done", done, (k == 12));
    end
    repeat (2) cycle();

    for (int sc = 0; sc < 45; sc++) begin
      int len;
      if (sc < 5) begin
        f_lo = 8'(cfg_lo[sc]); f_hi = 8'(cfg_hi[sc]); step = 8'(cfg_st[sc]);
        dwell = DW'(cfg_dw[sc]); mode = cfg_md[sc][0];
      end else begin
        f_lo = 8'($urandom_range(0, 255));
        f_hi = ($urandom_range(0, 5) == 0) ? f_lo : 8'($urandom_range(0, 255));
        step = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 9));
        dwell = DW'($urandom_range(0, 4));
        mode = 1'($urandom_range(0, 1));
      end
      start = 1'b1;
      stop = (sc >= 5 && $urandom_range(0, 7) == 0);
      cycle();
      start = 1'b0; stop = 1'b0;
      len = (sc < 5) ? 80 : $urandom_range(20, 150);
      for (int c = 0; c < len; c++) begin
        if (sc >= 5) begin
          start = ($urandom_range(0, 7) == 0);
          stop  = ($urandom_range(0, 79) == 0);
          rst_n = ($urandom_range(0, 299) != 0);
          if ($urandom_range(0, 15) == 0) begin
            f_lo = 8'($urandom); f_hi = 8'($urandom); step = 8'($urandom);
            dwell = DW'($urandom_range(0, 4)); mode = 1'($urandom);
          end
        end
        cycle();
      end
      start = 1'b0; rst_n = 1'b1; stop = 1'b1;
      cycle();
      stop = 1'b0;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
